// File: rtl/bs_split.sv
// bs_split: bit-stream extractor for the decoder path.
//
// Packed words arrive on val_i/dat_i. They are read MSB-first: dat_i[31] of the
// first word is the first bit of the stream. The consumer asks for a field of
// numb_i+1 bits with req_i. The field comes back on dat_o one cycle later,
// right-aligned with val_o pulsing high.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   val_i      input word valid
//   dat_i      input word, MSB = earliest bit
//   rdy_o      word accepted when val_i && rdy_o (buffered count <= DATA_WD)
//   req_i      field request
//   numb_i     requested field length minus 1
//   req_rdy_o  request served when req_i && req_rdy_o (enough bits buffered)
//   val_o      registered one-cycle field-valid pulse
//   dat_o      registered field, right-aligned, upper bits zero
//   cnt_o      number of buffered bits
//   align_i    (only with BS_SPLIT_ALIGN_EN) skip to the next byte boundary
//
// Optional feature macro: BS_SPLIT_ALIGN_EN adds align_i and a consumed-bit
// counter. The default build has neither.

module bs_split #(
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned NUMB_WD = 5,
    parameter int unsigned CNT_WD  = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               val_i,
    input  logic [DATA_WD-1:0] dat_i,
    output logic               rdy_o,
`ifdef BS_SPLIT_ALIGN_EN
    input  logic               align_i,
`endif
    input  logic               req_i,
    input  logic [NUMB_WD-1:0] numb_i,
    output logic               req_rdy_o,
    output logic               val_o,
    output logic [DATA_WD-1:0] dat_o,
    output logic [CNT_WD-1:0]  cnt_o
);

    localparam int unsigned BufWd = 2 * DATA_WD;

    // Valid bits live in buf_q[cnt_q-1:0]; the oldest bit is at cnt_q-1.
    logic [BufWd-1:0]   buf_q, buf_d;
    logic [CNT_WD-1:0]  cnt_q, cnt_d;
    logic               val_q, val_d;
    logic [DATA_WD-1:0] dat_q, dat_d;

    logic [CNT_WD-1:0]  take_n;
    logic [CNT_WD-1:0]  shamt;
    logic [BufWd-1:0]   mask;
    logic [BufWd-1:0]   field;
    logic [CNT_WD-1:0]  drop_n;
    logic               push;
    logic               serve;

    // Widen before adding so numb_i = all-ones gives a full-width field.
    assign take_n    = CNT_WD'(numb_i) + CNT_WD'(1);
    assign rdy_o     = (cnt_q <= CNT_WD'(DATA_WD));
    assign req_rdy_o = (cnt_q >= take_n);
    assign push      = val_i && rdy_o;
    assign serve     = req_i && req_rdy_o;

    // The oldest take_n bits sit directly below cnt_q.
    assign shamt = cnt_q - take_n;
    assign mask  = (BufWd'(1) << take_n) - BufWd'(1);
    assign field = (buf_q >> shamt) & mask;

`ifdef BS_SPLIT_ALIGN_EN
    logic [2:0] cons_q, cons_d;
    logic       align_go;
    logic [2:0] drop3;

    // A request wins over align when both are asserted.
    assign align_go = align_i && !req_i;
    // Round the consumed count up to the next byte: drop (8 - cons) mod 8 bits.
    assign drop3    = 3'(4'd8 - {1'b0, cons_q});
    assign drop_n   = align_go ? CNT_WD'(drop3) : '0;

    always_comb begin
        cons_d = cons_q;
        if (serve) begin
            cons_d = cons_q + take_n[2:0];
        end else if (align_go) begin
            cons_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cons_q <= 3'd0;
        end else begin
            cons_q <= cons_d;
        end
    end
`else
    assign drop_n = '0;
`endif

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q - drop_n;
        val_d = serve;
        dat_d = dat_q;
        if (serve) begin
            cnt_d = cnt_d - take_n;
            dat_d = DATA_WD'(field);
        end
        if (push) begin
            // Bits shifted out at the top are already consumed or invalid.
            buf_d = (buf_q << DATA_WD) | BufWd'(dat_i);
            cnt_d = cnt_d + CNT_WD'(DATA_WD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
            val_q <= 1'b0;
            dat_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            val_q <= val_d;
            dat_q <= dat_d;
        end
    end

    assign val_o = val_q;
    assign dat_o = dat_q;
    assign cnt_o = cnt_q;

endmodule

// File: tb/tb_bs_split.sv
// tb_bs_split: self-checking bench for bs_split.
// The reference model is a plain bit queue holding the stream, oldest bit first.

module tb_bs_split;

    logic        clk = 1'b0;
    logic        rst;
    logic        val_i;
    logic [31:0] dat_i;
    logic        rdy_o;
    logic        align_i;
    logic        req_i;
    logic [4:0]  numb_i;
    logic        req_rdy_o;
    logic        val_o;
    logic [31:0] dat_o;
    logic [6:0]  cnt_o;

    int checks = 0;
    int errors = 0;

    bit          mq[$];
    logic [31:0] last_dat;
    int          cons_tot;

    always #5 clk = ~clk;

    bs_split dut (
        .clk       (clk),
        .rst       (rst),
        .val_i     (val_i),
        .dat_i     (dat_i),
        .rdy_o     (rdy_o),
`ifdef BS_SPLIT_ALIGN_EN
        .align_i   (align_i),
`endif
        .req_i     (req_i),
        .numb_i    (numb_i),
        .req_rdy_o (req_rdy_o),
        .val_o     (val_o),
        .dat_o     (dat_o),
        .cnt_o     (cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs against the model,
    // advance the model, then check the registered outputs after the edge.
    task automatic cycle(input logic r, input logic vi, input logic [31:0] d,
                         input logic rq, input logic [4:0] nb, input logic al);
        int          n;
        bit          m_push, m_serve, m_align;
        logic [31:0] fld;
        rst = r; val_i = vi; dat_i = d; req_i = rq; numb_i = nb; align_i = al;
        #1;
        n = int'(nb) + 1;
        if (!r) begin
            check("rdy_o", 64'(rdy_o), 64'(mq.size() <= 32));
            check("req_rdy_o", 64'(req_rdy_o), 64'(mq.size() >= n));
        end
        m_push  = vi && (mq.size() <= 32);
        m_serve = rq && (mq.size() >= n);
`ifdef BS_SPLIT_ALIGN_EN
        m_align = al && !rq;
`else
        m_align = 1'b0;
`endif
        fld = '0;
        if (m_serve) begin
            for (int i = 0; i < n; i++) fld = {fld[30:0], mq.pop_front()};
            cons_tot += n;
            last_dat = fld;
        end else if (m_align) begin
            while (cons_tot % 8 != 0) begin
                void'(mq.pop_front());
                cons_tot++;
            end
        end
        if (m_push) begin
            for (int i = 31; i >= 0; i--) mq.push_back(d[i]);
        end
        if (r) begin
            mq.delete();
            last_dat = '0;
            cons_tot = 0;
            m_serve  = 1'b0;
        end
        @(posedge clk);
        #1;
        check("val_o", 64'(val_o), 64'(m_serve));
        check("dat_o", 64'(dat_o), 64'(last_dat));
        check("cnt_o", 64'(cnt_o), 64'(mq.size()));
    endtask

    initial begin
        int          pend;
        logic [4:0]  pnb;
        logic [31:0] w;
        rst = 1'b1; val_i = 0; dat_i = '0; req_i = 0; numb_i = '0; align_i = 0;
        last_dat = '0; cons_tot = 0;
        @(posedge clk); #1;
        cycle(1, 0, 0, 0, 0, 0);
        check("reset_cnt", 64'(cnt_o), 64'd0);
        check("reset_rdy", 64'(rdy_o), 64'd1);

        // DEADBEEF split 4/8/20
        cycle(0, 1, 32'hDEADBEEF, 0, 0, 0);
        cycle(0, 0, 0, 1, 5'd3, 0);
        check("t1_d", 64'(dat_o), 64'hD);
        cycle(0, 0, 0, 1, 5'd7, 0);
        check("t1_ea", 64'(dat_o), 64'hEA);
        cycle(0, 0, 0, 1, 5'd19, 0);
        check("t1_dbeef", 64'(dat_o), 64'hDBEEF);
        check("t1_cnt", 64'(cnt_o), 64'd0);

        // Two words, 12 then a full 32 across the word boundary
        cycle(0, 1, 32'h12345678, 0, 0, 0);
        cycle(0, 1, 32'h9ABCDEF0, 0, 0, 0);
        cycle(0, 0, 0, 1, 5'd11, 0);
        check("t2_123", 64'(dat_o), 64'h123);
        cycle(0, 0, 0, 1, 5'd31, 0);
        check("t2_full", 64'(dat_o), 64'h456789AB);
        check("t2_cnt", 64'(cnt_o), 64'd20);
        cycle(0, 0, 0, 1, 5'd19, 0);

        // Empty stall, then served after a push
        cycle(0, 0, 0, 1, 5'd0, 0);
        check("t3_stall", 64'(val_o), 64'd0);
        cycle(0, 1, 32'h80000000, 1, 5'd0, 0);
        cycle(0, 0, 0, 1, 5'd0, 0);
        check("t3_bit", 64'(dat_o), 64'h1);
        cycle(0, 0, 0, 1, 5'd30, 0);

        // Full-buffer backpressure and simultaneous push+take
        cycle(0, 1, 32'h01234567, 0, 0, 0);
        cycle(0, 1, 32'h89ABCDEF, 0, 0, 0);
        cycle(0, 1, 32'hFFFFFFFF, 1, 5'd23, 0);
        check("t4_cnt40", 64'(cnt_o), 64'd40);
        check("t4_rdy0", 64'(rdy_o), 64'd0);
        cycle(0, 1, 32'hFFFFFFFF, 1, 5'd7, 0);
        check("t4_cnt32", 64'(cnt_o), 64'd32);
        cycle(0, 1, 32'hCAFEF00D, 1, 5'd7, 0);
        check("t4_cnt56", 64'(cnt_o), 64'd56);
        cycle(0, 0, 0, 1, 5'd15, 0);
        check("t5_cnt40", 64'(cnt_o), 64'd40);

        // Reset with a request in flight
        cycle(1, 0, 0, 1, 5'd3, 0);
        check("t5_cnt", 64'(cnt_o), 64'd0);
        check("t5_val", 64'(val_o), 64'd0);
        check("t5_dat", 64'(dat_o), 64'd0);
        check("t5_rdy", 64'(rdy_o), 64'd1);

`ifdef BS_SPLIT_ALIGN_EN
        cycle(0, 1, 32'hA5FF0000, 0, 0, 0);
        cycle(0, 0, 0, 1, 5'd2, 0);
        cycle(0, 0, 0, 0, 0, 1);
        check("t6_cnt", 64'(cnt_o), 64'd24);
        cycle(0, 0, 0, 1, 5'd7, 0);
        check("t6_ff", 64'(dat_o), 64'hFF);
        cycle(1, 0, 0, 0, 0, 0);
`endif

        // Random traffic; a pending request is held until served
        pend = 0;
        pnb  = '0;
        for (int k = 0; k < 400; k++) begin
            if (pend == 0 && $urandom_range(0, 2) != 0) begin
                pend = 1;
                pnb  = 5'($urandom_range(0, 31));
            end
            w = $urandom;
            if (pend != 0 && mq.size() >= int'(pnb) + 1) begin
                cycle(0, 1'($urandom_range(0, 1)), w, 1, pnb, 0);
                pend = 0;
            end else begin
                cycle(0, 1'($urandom_range(0, 1)), w, 1'(pend), pnb,
                      1'($urandom_range(0, 7) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
